bcd_serial_addsub: RTL

Parametrised, digit-serial BCD adder/subtractor for NDIG-digit packed-BCD operands. It processes one BCD digit per clock, least-significant digit first, and reuses a single one-digit BCD add cell. Operands enter on a valid/ready handshake, and the result leaves on a second valid/ready handshake. It adds subtraction, invalid-digit detection and back-pressure, replacing the single-digit combinational adder in the arithmetic datapath.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_add.sv | 24 ++
 rtl/bcd_serial_addsub.sv | 110 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the digit-serial BCD add/subtract datapath.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return BCD_MAX - digit;
  endfunction

  function automatic logic digit_invalid(input logic [3:0] digit);
    return digit > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add cell: binary sum with +6 decimal adjust above nine.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       ci,
  output logic [3:0] s_d,
  output logic       co
);

  logic [4:0] s;

  always_comb begin
    s   = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, ci};
    s_d = s[3:0];
    co  = 1'b0;
    if (s > {1'b0, BCD_MAX}) begin
      s_d = s[3:0] + BCD_ADJ;
      co  = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, one shared digit cell,
// valid/ready on both operand and result sides.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam int CW = $clog2(NDIG + 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [4*NDIG-1:0] opa, opb;
  logic              sub_r, carry;
  logic [3:0]        a_d, b_raw, b_d, s_d;
  logic              co, in_bad, last;

  bcd_digit_add u_cell (
    .a_d (a_d),
    .b_d (b_d),
    .ci  (carry),
    .s_d (s_d),
    .co  (co)
  );

  // Subtraction runs as A + 9's-complement(B) + ~borrow; the final carry is then "no borrow".
  always_comb begin
    in_bad = 1'b0;
    a_d    = '0;
    b_raw  = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      in_bad = in_bad | digit_invalid(a[4*i +: 4]) | digit_invalid(b[4*i +: 4]);
      if (cnt == CW'(i)) begin
        a_d   = opa[4*i +: 4];
        b_raw = opb[4*i +: 4];
      end
    end
    b_d  = sub_r ? nines_comp(b_raw) : b_raw;
    last = (cnt == CW'(NDIG - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            sub_r <= sub;
            carry <= sub ? ~cin : cin;
            err   <= in_bad;
            cnt   <= '0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) sum[4*i +: 4] <= s_d;
          end
          carry <= co;
          cnt   <= cnt + CW'(1);
          // Last digit: the later clear overrides the digit write when err is set.
          if (last) begin
            cout <= co & ~err;
            if (err) sum <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
